// File: rtl/mem_loader_pkg.sv
// Shared definitions for the byte-stream memory loader.
//   DataW          : memory word width (two bytes per word)
//   FrameHdrBytes  : ADDR(2) + CNT(2) header bytes ahead of the payload
//   loader_state_e : loader FSM encoding
//   is_byte_state  : true in every state that accepts a byte from the receiver
package mem_loader_pkg;

  localparam int unsigned BytesPerWord  = 2;
  localparam int unsigned DataW         = BytesPerWord * 8;
  localparam int unsigned FrameHdrBytes = 4;

  typedef enum logic [3:0] {
    StIdle,
    StAddrHi,
    StAddrLo,
    StCntHi,
    StCntLo,
    StDatHi,
    StDatLo,
    StWrA,
    StWrM,
    StChkHi,
    StChkLo,
    StFin
  } loader_state_e;

  function automatic logic is_byte_state(loader_state_e s);
    return s inside {StAddrHi, StAddrLo, StCntHi, StCntLo, StDatHi, StDatLo, StChkHi, StChkLo};
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Loader-facing bundle: start pulse, byte stream from the UART receiver, data memory write port
// and loader status.
//   master : loader side (consumes start/rx stream, drives memory port and status)
//   slave  : environment side (receiver, memory block, controller)
interface mem_loader_if;
  import mem_loader_pkg::*;

  logic             start;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             reg_a_en;
  logic             reg_d_en;
  logic             reg_m_en;
  logic [DataW-1:0] data_out;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, rx_data, rx_valid,
    output rx_ready, reg_a_en, reg_d_en, reg_m_en, data_out, cpu_hold, busy, done, err
  );

  modport slave (
    output start, rx_data, rx_valid,
    input  rx_ready, reg_a_en, reg_d_en, reg_m_en, data_out, cpu_hold, busy, done, err
  );

endinterface

// File: rtl/mem_loader_timer.sv
// Inter-byte timeout: loadable down-counter.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset
//   clear_i   : reload with Cycles
//   tick_i    : count one idle cycle
//   expired_o : counter has reached zero
module mem_loader_timer #(
  parameter int unsigned Cycles = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Cycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = CntW'(Cycles);
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mem_loader.sv
// Byte-stream program loader. Takes big-endian frames ADDR(2) CNT(2) DATA(2*CNT) from a UART
// receiver and writes each word to data memory via an A-register load followed by a memory write,
// holding the CPU off the memory port meanwhile.
// Optional feature macro MEM_LOADER_CHECKSUM_EN: frame carries a trailing 16-bit sum of the data
// words; a mismatch ends the frame with err (already written words stay).
//   clk_i  : clock, all logic on posedge
//   rst_ni : synchronous active-low reset
//   bus    : mem_loader_if.master (start, rx stream, memory strobes/data, status)
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned AddrW         = 13,
  parameter int unsigned TimeoutCycles = 1000000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  mem_loader_if.master bus
);

  loader_state_e    state_q, state_d;
  logic [7:0]       byte_hi_q, byte_hi_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [DataW-1:0] word_q, word_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DataW-1:0] chk_q, chk_d;
`endif

  logic             rx_ready;
  logic             accept;
  logic [15:0]      rx_pair;
  logic             tmr_clear, tmr_tick, tmr_expired;

  assign rx_ready = is_byte_state(state_q);
  assign accept   = bus.rx_valid && rx_ready;
  assign rx_pair  = {byte_hi_q, bus.rx_data};

  mem_loader_timer #(
    .Cycles (TimeoutCycles)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (tmr_clear),
    .tick_i    (tmr_tick),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    byte_hi_d = byte_hi_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    tmr_clear = 1'b0;
    tmr_tick  = 1'b0;

    unique case (state_q)
      // FIN behaves like IDLE for one cycle so a start right after done is not lost
      StIdle, StFin: begin
        state_d = StIdle;
        if (bus.start) begin
          state_d   = StAddrHi;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          tmr_clear = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
          chk_d     = '0;
`endif
        end
      end
      StAddrHi, StCntHi, StDatHi, StChkHi: begin
        if (accept) begin
          byte_hi_d = bus.rx_data;
          unique case (state_q)
            StAddrHi: state_d = StAddrLo;
            StCntHi:  state_d = StCntLo;
            StDatHi:  state_d = StDatLo;
            default:  state_d = StChkLo;
          endcase
        end
      end
      StAddrLo: begin
        if (accept) begin
          addr_d  = AddrW'(rx_pair);
          state_d = StCntHi;
        end
      end
      StCntLo: begin
        if (accept) begin
          cnt_d = rx_pair;
          if (rx_pair == 16'd0) begin
`ifdef MEM_LOADER_CHECKSUM_EN
            state_d = StChkHi;
`else
            state_d = StFin;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = StDatHi;
          end
        end
      end
      StDatLo: begin
        if (accept) begin
          word_d  = rx_pair;
`ifdef MEM_LOADER_CHECKSUM_EN
          chk_d   = chk_q + rx_pair;
`endif
          state_d = StWrA;
        end
      end
      StWrA: state_d = StWrM;
      StWrM: begin
        addr_d = addr_q + AddrW'(1);
        if (cnt_q == 16'd1) begin
`ifdef MEM_LOADER_CHECKSUM_EN
          state_d = StChkHi;
`else
          state_d = StFin;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q - 16'd1;
          state_d = StDatHi;
        end
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      StChkLo: begin
        if (accept) begin
          busy_d = 1'b0;
          if (rx_pair == chk_q) begin
            state_d = StFin;
            done_d  = 1'b1;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Timeout supervision; an accepted byte always wins over expiry in the same cycle
    if (rx_ready) begin
      if (accept) begin
        tmr_clear = 1'b1;
      end else if (tmr_expired) begin
        state_d = StIdle;
        busy_d  = 1'b0;
        err_d   = 1'b1;
      end else begin
        tmr_tick = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      byte_hi_q <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      byte_hi_q <= byte_hi_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef MEM_LOADER_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  // Strobes decode straight from the state, so they can never overlap
  always_comb begin
    bus.data_out = '0;
    if (state_q == StWrA) begin
      bus.data_out = DataW'(addr_q);
    end else if (state_q == StWrM) begin
      bus.data_out = word_q;
    end
  end

  assign bus.rx_ready = rx_ready;
  assign bus.reg_a_en = (state_q == StWrA);
  assign bus.reg_m_en = (state_q == StWrM);
  assign bus.reg_d_en = 1'b0;
  assign bus.busy     = busy_q;
  assign bus.cpu_hold = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: drives frames byte by byte, models the memory block
// (A register + word array) and scores every memory write against a queue of expected writes.
// Builds with or without MEM_LOADER_CHECKSUM_EN.
module tb_mem_loader;
  import mem_loader_pkg::*;

  typedef struct {
    logic [12:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  mem_loader_if bus ();

  mem_loader #(
    .AddrW         (13),
    .TimeoutCycles (16)
  ) u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int          unexp_n = 0;
  int          overlap_n = 0;
  int          stray_n = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [15:0] words_q[$];
  logic [15:0] mem[8192];
  logic [15:0] a_reg = '0;
  logic [15:0] chk_acc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Memory block model plus write scoreboard
  always @(negedge clk_i) begin
    if (bus.reg_a_en && bus.reg_m_en) overlap_n++;
    if (bus.reg_d_en || (!bus.reg_a_en && !bus.reg_m_en && bus.data_out != '0)) stray_n++;
    if (bus.reg_a_en) a_reg = bus.data_out;
    if (bus.reg_m_en) begin
      mem[a_reg[12:0]] = bus.data_out;
      if (exp_q.size() == 0) begin
        unexp_n++;
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", a_reg, {3'b0, mon_e.addr});
        check("wr_data", bus.data_out, mon_e.data);
      end
    end
  end

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk_i);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    check("rx_accept", bus.rx_ready, 1);
    @(negedge clk_i);
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk_i);
    bus.start = 1'b0;
  endtask

  task automatic begin_frame(input logic [15:0] addr, input logic [15:0] cnt);
    logic [31:0] hdr;
    hdr     = {addr, cnt};
    chk_acc = '0;
    pulse_start();
    check("start_busy", bus.busy, 1);
    check("start_hold", bus.cpu_hold, 1);
    check("start_done", bus.done, 0);
    check("start_err", bus.err, 0);
    for (int i = 0; i < int'(FrameHdrBytes); i++) begin
      if (i != 0) gap();
      send_byte(hdr[31-8*i -: 8]);
    end
  endtask

  task automatic send_words(input logic [15:0] addr, input int first, input int n);
    wr_t e;
    for (int i = first; i < first + n; i++) begin
      e.addr = 13'(addr + 16'(i));
      e.data = words_q[i];
      exp_q.push_back(e);
      chk_acc += words_q[i];
      gap();
      send_byte(words_q[i][15:8]);
      gap();
      send_byte(words_q[i][7:0]);
    end
  endtask

  // Called straight after the last data byte (or CNT_LO when there are no words)
  task automatic finish_frame(input bit has_words, input bit bad_chk);
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [15:0] c;
`endif
    if (has_words) begin
      check("lat_a_en", bus.reg_a_en, 1);
      @(negedge clk_i);
      check("lat_m_en", bus.reg_m_en, 1);
      @(negedge clk_i);
    end
`ifdef MEM_LOADER_CHECKSUM_EN
    c = chk_acc ^ {15'b0, bad_chk};
    send_byte(c[15:8]);
    gap();
    send_byte(c[7:0]);
`endif
    check("end_done", bus.done, 32'(!bad_chk));
    check("end_err", bus.err, 32'(bad_chk));
    check("end_busy", bus.busy, 0);
    check("end_hold", bus.cpu_hold, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    rst_ni       = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_busy", bus.busy, 0);
    check("rst_hold", bus.cpu_hold, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_ready", bus.rx_ready, 0);
    check("rst_strobes", {bus.reg_a_en, bus.reg_d_en, bus.reg_m_en}, 0);
    check("rst_data", bus.data_out, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Bytes offered while idle are refused
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    repeat (4) @(negedge clk_i);
    check("idle_ready", bus.rx_ready, 0);
    check("idle_busy", bus.busy, 0);
    bus.rx_valid = 1'b0;

    // Basic frame, plus a start pulse mid-frame that must be ignored
    words_q = '{16'h1234, 16'hBEEF};
    begin_frame(16'h000A, 16'd2);
    pulse_start();
    check("midstart_busy", bus.busy, 1);
    check("midstart_done", bus.done, 0);
    send_words(16'h000A, 0, 2);
    finish_frame(1'b1, 1'b0);
    check("mem_000a", mem[10], 16'h1234);
    check("mem_000b", mem[11], 16'hBEEF);

    // Address wrap at the top of memory
    words_q = '{16'hA001, 16'hA002, 16'hA003};
    begin_frame(16'h1FFF, 16'd3);
    send_words(16'h1FFF, 0, 3);
    finish_frame(1'b1, 1'b0);
    check("mem_1fff", mem[13'h1FFF], 16'hA001);
    check("mem_0000", mem[0], 16'hA002);
    check("mem_0001", mem[1], 16'hA003);

    // Inter-byte timeout after ADDR_HI
    pulse_start();
    check("to_start_busy", bus.busy, 1);
    send_byte(8'h00);
    n = 0;
    while (!bus.err && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check("to_latency_ok", 32'(n >= 16 && n <= 18), 1);
    check("to_busy", bus.busy, 0);
    check("to_hold", bus.cpu_hold, 0);
    check("to_done", bus.done, 0);

    // Empty frame (start also clears the sticky err); then rx_valid held high while idle
    words_q = {};
    begin_frame(16'h0123, 16'd0);
    finish_frame(1'b0, 1'b0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    repeat (5) @(negedge clk_i);
    check("cnt0_idle_ready", bus.rx_ready, 0);
    check("cnt0_idle_busy", bus.busy, 0);
    check("cnt0_idle_done", bus.done, 1);
    bus.rx_valid = 1'b0;

    // Reset in the middle of a 5-word frame, after 3 words are written
    words_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    begin_frame(16'h0100, 16'd5);
    send_words(16'h0100, 0, 3);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("mrst_busy", bus.busy, 0);
    check("mrst_hold", bus.cpu_hold, 0);
    check("mrst_ready", bus.rx_ready, 0);
    check("mrst_done", bus.done, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check("mrst_drain", exp_q.size(), 0);
    check("mrst_mem0", mem[13'h100], 16'h1111);
    check("mrst_mem1", mem[13'h101], 16'h2222);
    check("mrst_mem2", mem[13'h102], 16'h3333);

    // Loader recovers after reset
    words_q = '{16'h0F0F};
    begin_frame(16'h0200, 16'd1);
    send_words(16'h0200, 0, 1);
    finish_frame(1'b1, 1'b0);
    check("mem_0200", mem[13'h200], 16'h0F0F);

`ifdef MEM_LOADER_CHECKSUM_EN
    // Checksum wraps mod 2**16: 0x0001 + 0xFFFF = 0x0000
    words_q = '{16'h0001, 16'hFFFF};
    begin_frame(16'h0300, 16'd2);
    send_words(16'h0300, 0, 2);
    finish_frame(1'b1, 1'b0);
    words_q = '{16'h0001, 16'hFFFF};
    begin_frame(16'h0310, 16'd2);
    send_words(16'h0310, 0, 2);
    finish_frame(1'b1, 1'b1);
    check("chk_bad_mem0", mem[13'h310], 16'h0001);
    check("chk_bad_mem1", mem[13'h311], 16'hFFFF);
`endif

    repeat (4) @(negedge clk_i);
    check("drain", exp_q.size(), 0);
    check("unexpected_wr", unexp_n, 0);
    check("strobe_overlap", overlap_n, 0);
    check("stray_data", stray_n, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
